// File: rtl/noc_sequencer_if.sv
// rtl/noc_sequencer_if.sv - control/status bundle between a run controller and the mesh sequencer
interface noc_sequencer_if #(
    parameter int NUM_ROUTERS = 8,
    parameter int RID_W       = 3,
    parameter int OP_W        = 3,
    parameter int CYCLE_W     = 16,
    parameter int TIDX_W      = 8
);
    logic                          start;
    logic [CYCLE_W-1:0]            max_cycle;
    logic                          stop_on_done;
    logic                          hold;
    logic [NUM_ROUTERS*TIDX_W-1:0] traffic_count;
    logic [NUM_ROUTERS-1:0]        rt_valid;
    logic [NUM_ROUTERS-1:0]        inject_ok;
    logic [NUM_ROUTERS-1:0]        router_done;
    logic [NUM_ROUTERS*OP_W-1:0]   router_op;
    logic [NUM_ROUTERS*OP_W-1:0]   traffic_op;
    logic [NUM_ROUTERS-1:0]        fill_en;
    logic [TIDX_W-1:0]             fill_idx;
    logic [RID_W-1:0]              rt_dst;
    logic [CYCLE_W-1:0]            in_cycle;
    logic                          busy;
    logic                          finished;

    modport master (
        output start, max_cycle, stop_on_done, hold, traffic_count,
               rt_valid, inject_ok, router_done,
        input  router_op, traffic_op, fill_en, fill_idx, rt_dst,
               in_cycle, busy, finished
    );

    modport slave (
        input  start, max_cycle, stop_on_done, hold, traffic_count,
               rt_valid, inject_ok, router_done,
        output router_op, traffic_op, fill_en, fill_idx, rt_dst,
               in_cycle, busy, finished
    );
endinterface

// File: rtl/noc_sequencer.sv
// rtl/noc_sequencer.sv - mesh bring-up and network-cycle sequencer
module noc_sequencer #(
    parameter int NUM_ROUTERS = 8,
    parameter int RID_W       = 3,
    parameter int OP_W        = 3,
    parameter int CYCLE_W     = 16,
    parameter int TIDX_W      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    noc_sequencer_if.slave bus
);
    localparam logic [OP_W-1:0] OP_NOP          = OP_W'(0);
    localparam logic [OP_W-1:0] OP_INIT         = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LOAD_RT      = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LOAD_STAGING = OP_W'(3);
    localparam logic [OP_W-1:0] OP_PHASE0       = OP_W'(4);
    localparam logic [OP_W-1:0] OP_PHASE1       = OP_W'(5);
    localparam logic [OP_W-1:0] OP_FILL         = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DEQUEUE      = OP_W'(7);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_TRAFFIC, S_FILL, S_INIT_ROUTER, S_LOAD_RT,
        S_LOAD_STAGING, S_PHASE0, S_PHASE1, S_DONE
    } state_t;

    state_t                      state, next_state;
    logic [TIDX_W-1:0]           remaining [NUM_ROUTERS];
    logic [TIDX_W-1:0]           fill_idx;
    logic [RID_W-1:0]            rt_dst;
    logic [CYCLE_W-1:0]          in_cycle;
    logic [CYCLE_W-1:0]          max_cycle_q;
    logic                        stop_q;
    logic [CYCLE_W-1:0]          cycle_next;
    logic                        any_remaining, rt_last, run_end, stalled, launch;
    logic [NUM_ROUTERS*OP_W-1:0] router_op, traffic_op;
    logic [NUM_ROUTERS-1:0]      fill_en;

    // Run-control conditions shared by the FSM and the counter datapath
    always_comb begin
        any_remaining = 1'b0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (remaining[i] != '0) any_remaining = 1'b1;
        end
        rt_last    = (rt_dst == RID_W'(NUM_ROUTERS - 1));
        cycle_next = in_cycle + 1'b1;
        run_end    = ((max_cycle_q != '0) && (cycle_next == max_cycle_q)) ||
                     (stop_q && (&bus.router_done));
        stalled    = bus.hold && (state inside {S_LOAD_STAGING, S_PHASE0, S_PHASE1});
        launch     = bus.start && (state inside {S_IDLE, S_DONE});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state and op decode; a stalled network state repeats with all ops NOP
    always_comb begin
        next_state = state;
        router_op  = {NUM_ROUTERS{OP_NOP}};
        traffic_op = {NUM_ROUTERS{OP_NOP}};
        fill_en    = '0;
        case (state)
            S_IDLE, S_DONE: if (bus.start) next_state = S_INIT_TRAFFIC;
            S_INIT_TRAFFIC: begin
                traffic_op = {NUM_ROUTERS{OP_INIT}};
                next_state = S_FILL;
            end
            S_FILL: begin
                if (any_remaining) begin
                    for (int i = 0; i < NUM_ROUTERS; i++) begin
                        if (remaining[i] != '0) begin
                            fill_en[i]                   = 1'b1;
                            traffic_op[i*OP_W +: OP_W] = OP_FILL;
                        end
                    end
                end else begin
                    next_state = S_INIT_ROUTER;
                end
            end
            S_INIT_ROUTER: begin
                router_op  = {NUM_ROUTERS{OP_INIT}};
                next_state = S_LOAD_RT;
            end
            S_LOAD_RT: begin
                for (int i = 0; i < NUM_ROUTERS; i++) begin
                    if (bus.rt_valid[i]) router_op[i*OP_W +: OP_W] = OP_LOAD_RT;
                end
                if (rt_last) next_state = S_LOAD_STAGING;
            end
            S_LOAD_STAGING: if (!stalled) begin
                router_op = {NUM_ROUTERS{OP_LOAD_STAGING}};
                for (int i = 0; i < NUM_ROUTERS; i++) begin
                    if (bus.inject_ok[i]) traffic_op[i*OP_W +: OP_W] = OP_DEQUEUE;
                end
                next_state = S_PHASE0;
            end
            S_PHASE0: if (!stalled) begin
                router_op  = {NUM_ROUTERS{OP_PHASE0}};
                next_state = S_PHASE1;
            end
            S_PHASE1: if (!stalled) begin
                router_op  = {NUM_ROUTERS{OP_PHASE1}};
                next_state = run_end ? S_DONE : S_LOAD_STAGING;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Counters and run configuration captured at launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ROUTERS; i++) remaining[i] <= '0;
            fill_idx    <= '0;
            rt_dst      <= '0;
            in_cycle    <= '0;
            max_cycle_q <= '0;
            stop_q      <= 1'b0;
        end else if (launch) begin
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                remaining[i] <= bus.traffic_count[i*TIDX_W +: TIDX_W];
            end
            fill_idx    <= '0;
            rt_dst      <= '0;
            in_cycle    <= '0;
            max_cycle_q <= bus.max_cycle;
            stop_q      <= bus.stop_on_done;
        end else begin
            case (state)
                S_FILL: if (any_remaining) begin
                    for (int i = 0; i < NUM_ROUTERS; i++) begin
                        if (remaining[i] != '0) remaining[i] <= remaining[i] - 1'b1;
                    end
                    fill_idx <= fill_idx + 1'b1;
                end
                S_LOAD_RT: if (!rt_last) rt_dst <= rt_dst + 1'b1;
                S_PHASE1:  if (!stalled) in_cycle <= cycle_next;
                default: ;
            endcase
        end
    end

    assign bus.router_op  = router_op;
    assign bus.traffic_op = traffic_op;
    assign bus.fill_en    = fill_en;
    assign bus.fill_idx   = fill_idx;
    assign bus.rt_dst     = rt_dst;
    assign bus.in_cycle   = in_cycle;
    assign bus.busy       = !(state inside {S_IDLE, S_DONE});
    assign bus.finished   = (state == S_DONE);
endmodule

// File: tb/tb_noc_sequencer.sv
// tb/tb_noc_sequencer.sv - self-checking bench for noc_sequencer
module tb_noc_sequencer;
    localparam int N   = 4;
    localparam int RID = 2;
    localparam int OP  = 3;
    localparam int CW  = 16;
    localparam int TW  = 8;

    localparam logic [OP-1:0] OP_INIT    = 3'd1;
    localparam logic [OP-1:0] OP_LOAD_RT = 3'd2;
    localparam logic [OP-1:0] OP_LS      = 3'd3;
    localparam logic [OP-1:0] OP_P0      = 3'd4;
    localparam logic [OP-1:0] OP_P1      = 3'd5;
    localparam logic [OP-1:0] OP_FILL    = 3'd6;
    localparam logic [OP-1:0] OP_DEQ     = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    noc_sequencer_if #(.NUM_ROUTERS(N), .RID_W(RID), .OP_W(OP), .CYCLE_W(CW), .TIDX_W(TW)) bus ();

    noc_sequencer #(.NUM_ROUTERS(N), .RID_W(RID), .OP_W(OP), .CYCLE_W(CW), .TIDX_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [OP-1:0] rop(input int i);
        return bus.router_op[i*OP +: OP];
    endfunction

    function automatic logic [N*OP-1:0] all_ops(input logic [OP-1:0] op);
        logic [N*OP-1:0] r;
        for (int i = 0; i < N; i++) r[i*OP +: OP] = op;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [N*TW-1:0] counts, input logic [CW-1:0] maxc, input logic stop);
        bus.traffic_count = counts;
        bus.max_cycle     = maxc;
        bus.stop_on_done  = stop;
        bus.start         = 1'b1;
        tick();
        bus.start         = 1'b0;
    endtask

    task automatic wait_finished(output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (bus.finished === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic found;
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: busy=%b finished=%b, expected 0 0", bus.busy, bus.finished);
        end
        tests_run++;
        if (bus.router_op !== '0 || bus.traffic_op !== '0 || bus.fill_en !== '0) begin
            tests_failed++;
            $display("FAIL reset_ops: router_op=%h traffic_op=%h fill_en=%b, expected all 0",
                     bus.router_op, bus.traffic_op, bus.fill_en);
        end
        tests_run++;
        if (bus.in_cycle !== '0 || bus.rt_dst !== '0 || bus.fill_idx !== '0) begin
            tests_failed++;
            $display("FAIL reset_counters: in_cycle=%0d rt_dst=%0d fill_idx=%0d, expected 0",
                     bus.in_cycle, bus.rt_dst, bus.fill_idx);
        end
        rst_n = 1'b1;
        tick();
        bus.rt_valid = '1;
        start_run('0, 16'd2, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.rt_dst === 2'd2 && rop(0) === OP_LOAD_RT) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL reset_reach_load_rt: rt_dst=%0d never reached 2 in LOAD_RT", bus.rt_dst);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.router_op !== '0 || bus.rt_dst !== '0 || bus.finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: busy=%b router_op=%h rt_dst=%0d finished=%b, expected 0 0 0 0",
                     bus.busy, bus.router_op, bus.rt_dst, bus.finished);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_load;
        logic [N-1:0]    exp_en [4];
        logic [N*OP-1:0] exp_top;
        logic            seen;
        exp_en = '{4'b0101, 4'b0001, 4'b0001, 4'b0000};
        bus.rt_valid = 4'b1010;
        start_run({8'd0, 8'd1, 8'd0, 8'd3}, 16'd1, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus.traffic_op !== all_ops(OP_INIT) || bus.router_op !== '0) begin
            tests_failed++;
            $display("FAIL init_traffic: traffic_op=%h router_op=%h", bus.traffic_op, bus.router_op);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_top = '0;
            for (int i = 0; i < N; i++) if (exp_en[k][i]) exp_top[i*OP +: OP] = OP_FILL;
            tests_run++;
            if (bus.fill_en !== exp_en[k] || bus.traffic_op !== exp_top) begin
                tests_failed++;
                $display("FAIL fill_cycle%0d: fill_en=%b traffic_op=%h, expected %b %h",
                         k, bus.fill_en, bus.traffic_op, exp_en[k], exp_top);
            end
            if (k < 3) begin
                tests_run++;
                if (bus.fill_idx !== TW'(k)) begin
                    tests_failed++;
                    $display("FAIL fill_idx%0d: fill_idx=%0d, expected %0d", k, bus.fill_idx, k);
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.router_op !== all_ops(OP_INIT)) begin
            tests_failed++;
            $display("FAIL init_router: router_op=%h", bus.router_op);
        end
        for (int d = 0; d < N; d++) begin
            @(negedge clk);
            tests_run++;
            if (bus.rt_dst !== RID'(d) || bus.router_op !== {OP_LOAD_RT, 3'd0, OP_LOAD_RT, 3'd0}) begin
                tests_failed++;
                $display("FAIL load_rt%0d: rt_dst=%0d router_op=%h, expected %0d 410",
                         d, bus.rt_dst, bus.router_op, d);
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.router_op !== all_ops(OP_LS)) begin
            tests_failed++;
            $display("FAIL after_load_rt: router_op=%h, expected LOAD_STAGING", bus.router_op);
        end
        wait_finished(seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL fill_run_end: finished=%b never rose", bus.finished);
        end
        tick();
    endtask

    task automatic test_max_cycle;
        int   n_ls, n_p0, n_p1;
        logic seen;
        n_ls = 0; n_p0 = 0; n_p1 = 0; seen = 1'b0;
        start_run('0, 16'd3, 1'b0);
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus.finished === 1'b1) seen = 1'b1;
            else if (rop(0) === OP_LS) n_ls++;
            else if (rop(0) === OP_P0) n_p0++;
            else if (rop(0) === OP_P1) n_p1++;
        end
        tests_run++;
        if (!seen || n_ls != 3 || n_p0 != 3 || n_p1 != 3) begin
            tests_failed++;
            $display("FAIL max_cycle_triplets: done=%b ls=%0d p0=%0d p1=%0d, expected 1 3 3 3",
                     seen, n_ls, n_p0, n_p1);
        end
        tests_run++;
        if (bus.in_cycle !== 16'd3 || bus.busy !== 1'b0 || bus.router_op !== '0) begin
            tests_failed++;
            $display("FAIL max_cycle_done: in_cycle=%0d busy=%b router_op=%h, expected 3 0 0",
                     bus.in_cycle, bus.busy, bus.router_op);
        end
        tick();
        start_run('0, 16'd3, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus.finished !== 1'b0 || bus.in_cycle !== '0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart: finished=%b in_cycle=%0d busy=%b, expected 0 0 1",
                     bus.finished, bus.in_cycle, bus.busy);
        end
        wait_finished(seen);
        tick();
    endtask

    task automatic test_stop_on_done;
        logic seen;
        seen = 1'b0;
        bus.inject_ok   = 4'b0100;
        bus.router_done = '0;
        start_run('0, 16'd0, 1'b1);
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.finished === 1'b1) seen = 1'b1;
            else if (rop(0) === OP_LS) begin
                tests_run++;
                if (bus.traffic_op !== {3'd0, OP_DEQ, 3'd0, 3'd0}) begin
                    tests_failed++;
                    $display("FAIL dequeue_ls: traffic_op=%h, expected 1c0", bus.traffic_op);
                end
                if (bus.in_cycle === 16'd5) bus.router_done = '1;
            end else if (rop(0) === OP_P0 || rop(0) === OP_P1) begin
                tests_run++;
                if (bus.traffic_op !== '0) begin
                    tests_failed++;
                    $display("FAIL dequeue_phase: traffic_op=%h, expected 0", bus.traffic_op);
                end
            end
        end
        tests_run++;
        if (!seen || bus.in_cycle !== 16'd6) begin
            tests_failed++;
            $display("FAIL stop_on_done: done=%b in_cycle=%0d, expected 1 6", seen, bus.in_cycle);
        end
        bus.router_done = '0;
        bus.inject_ok   = '0;
        tick();
    endtask

    task automatic test_hold;
        logic found, seen;
        found = 1'b0;
        start_run('0, 16'd4, 1'b0);
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (rop(0) === OP_LS && bus.in_cycle === 16'd1) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL hold_reach: in_cycle=%0d never saw LOAD_STAGING at cycle 1", bus.in_cycle);
        end
        tick();
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.router_op !== '0 || bus.traffic_op !== '0 || bus.in_cycle !== 16'd1 || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold_nop%0d: router_op=%h traffic_op=%h in_cycle=%0d busy=%b, expected 0 0 1 1",
                         k, bus.router_op, bus.traffic_op, bus.in_cycle, bus.busy);
            end
        end
        tick();
        bus.hold = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.router_op !== all_ops(OP_P0)) begin
            tests_failed++;
            $display("FAIL hold_resume_p0: router_op=%h, expected PHASE0", bus.router_op);
        end
        @(negedge clk);
        tests_run++;
        if (bus.router_op !== all_ops(OP_P1) || bus.in_cycle !== 16'd1) begin
            tests_failed++;
            $display("FAIL hold_resume_p1: router_op=%h in_cycle=%0d, expected PHASE1 1",
                     bus.router_op, bus.in_cycle);
        end
        @(negedge clk);
        tests_run++;
        if (bus.router_op !== all_ops(OP_LS) || bus.in_cycle !== 16'd2) begin
            tests_failed++;
            $display("FAIL hold_next_cycle: router_op=%h in_cycle=%0d, expected LOAD_STAGING 2",
                     bus.router_op, bus.in_cycle);
        end
        wait_finished(seen);
        tests_run++;
        if (!seen || bus.in_cycle !== 16'd4) begin
            tests_failed++;
            $display("FAIL hold_run_end: done=%b in_cycle=%0d, expected 1 4", seen, bus.in_cycle);
        end
        tick();
    endtask

    task automatic test_random;
        logic [N*TW-1:0] counts;
        int              cnt [N];
        int              m, cyc, ph, done_at, k, a;
        logic [CW-1:0]   maxc;
        logic            stop, ended, chk_idx, chk_dst;
        int              kind [$];
        int              arg  [$];
        logic [N*OP-1:0] exp_rop, exp_top;
        logic [N-1:0]    exp_en;
        logic [TW-1:0]   exp_idx;
        logic [RID-1:0]  exp_dst;
        logic [CW-1:0]   exp_in;
        for (int run = 0; run < 6; run++) begin
            m = 0;
            for (int i = 0; i < N; i++) begin
                cnt[i] = $urandom_range(0, 5);
                counts[i*TW +: TW] = TW'(cnt[i]);
                if (cnt[i] > m) m = cnt[i];
            end
            stop    = 1'($urandom_range(0, 1));
            maxc    = stop ? CW'($urandom_range(0, 5)) : CW'($urandom_range(1, 6));
            done_at = $urandom_range(0, 6);
            kind.delete();
            arg.delete();
            kind.push_back(0); arg.push_back(0);
            for (int f = 0; f <= m; f++) begin kind.push_back(1); arg.push_back(f); end
            kind.push_back(2); arg.push_back(0);
            for (int d = 0; d < N; d++) begin kind.push_back(3); arg.push_back(d); end
            cyc = 0; ph = 0; ended = 1'b0;
            start_run(counts, maxc, stop);
            for (int c = 0; c < 400 && !ended; c++) begin
                bus.rt_valid    = N'($urandom);
                bus.inject_ok   = N'($urandom);
                bus.hold        = ($urandom_range(0, 3) == 0);
                bus.router_done = (cyc >= done_at) ? '1 : {1'b0, 3'($urandom)};
                @(negedge clk);
                exp_rop = '0; exp_top = '0; exp_en = '0; exp_in = CW'(cyc);
                exp_idx = '0; exp_dst = '0; chk_idx = 1'b0; chk_dst = 1'b0;
                if (kind.size() > 0) begin
                    k = kind.pop_front();
                    a = arg.pop_front();
                    case (k)
                        0: exp_top = all_ops(OP_INIT);
                        1: begin
                            chk_idx = 1'b1;
                            exp_idx = TW'(a);
                            for (int i = 0; i < N; i++) begin
                                if (cnt[i] > a) begin
                                    exp_en[i] = 1'b1;
                                    exp_top[i*OP +: OP] = OP_FILL;
                                end
                            end
                        end
                        2: exp_rop = all_ops(OP_INIT);
                        default: begin
                            chk_dst = 1'b1;
                            exp_dst = RID'(a);
                            for (int i = 0; i < N; i++) if (bus.rt_valid[i]) exp_rop[i*OP +: OP] = OP_LOAD_RT;
                        end
                    endcase
                end else if (!bus.hold) begin
                    case (ph)
                        0: begin
                            exp_rop = all_ops(OP_LS);
                            for (int i = 0; i < N; i++) if (bus.inject_ok[i]) exp_top[i*OP +: OP] = OP_DEQ;
                        end
                        1: exp_rop = all_ops(OP_P0);
                        default: exp_rop = all_ops(OP_P1);
                    endcase
                    if (ph == 2) begin
                        cyc++;
                        ph = 0;
                        if ((maxc != '0 && cyc == int'(maxc)) || (stop && (&bus.router_done))) ended = 1'b1;
                    end else begin
                        ph++;
                    end
                end
                tests_run++;
                if (bus.router_op !== exp_rop || bus.traffic_op !== exp_top || bus.fill_en !== exp_en) begin
                    tests_failed++;
                    $display("FAIL rand_ops run%0d cyc%0d: router_op=%h traffic_op=%h fill_en=%b, expected %h %h %b",
                             run, c, bus.router_op, bus.traffic_op, bus.fill_en, exp_rop, exp_top, exp_en);
                end
                tests_run++;
                if (bus.busy !== 1'b1 || bus.finished !== 1'b0 || bus.in_cycle !== exp_in ||
                    (chk_idx && bus.fill_idx !== exp_idx) || (chk_dst && bus.rt_dst !== exp_dst)) begin
                    tests_failed++;
                    $display("FAIL rand_status run%0d cyc%0d: busy=%b finished=%b in_cycle=%0d fill_idx=%0d rt_dst=%0d, expected 1 0 %0d %0d %0d",
                             run, c, bus.busy, bus.finished, bus.in_cycle, bus.fill_idx, bus.rt_dst,
                             exp_in, exp_idx, exp_dst);
                end
                tick();
            end
            bus.hold = 1'b0;
            @(negedge clk);
            tests_run++;
            if (!ended || bus.finished !== 1'b1 || bus.busy !== 1'b0 || bus.in_cycle !== CW'(cyc)) begin
                tests_failed++;
                $display("FAIL rand_end run%0d: ended=%b finished=%b busy=%b in_cycle=%0d, expected 1 1 0 %0d",
                         run, ended, bus.finished, bus.busy, bus.in_cycle, cyc);
            end
            tick();
        end
        bus.router_done = '0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.max_cycle     = '0;
        bus.stop_on_done  = 1'b0;
        bus.hold          = 1'b0;
        bus.traffic_count = '0;
        bus.rt_valid      = '0;
        bus.inject_ok     = '0;
        bus.router_done   = '0;
        test_reset();
        test_fill_load();
        test_max_cycle();
        test_stop_on_done();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
